// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch stage.
// Holds the fetch FSM state encoding and the PC increment constant.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_INC = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with stall buffering and redirect drain.
// Ports: clk, rst (async, active-high); imem_req/imem_addr/imem_rdy/imem_rdata
//   to instruction memory; ifid_write (IF/ID accept), redirect/redirect_pc;
//   instr_o, pc_o (fetch addr + 4), ifid_flush_o to the IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    input  logic        ifid_write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        ifid_flush_o
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  hold_instr;
    logic [31:0]  pend_pc;
    logic [31:0]  pc_inc;
    logic [31:0]  rd_pc;

    assign pc_inc = pc + PC_INC;
    assign rd_pc  = word_align(redirect_pc);

    // In DRAIN, pc still holds the stale address whose request is completing.
    assign imem_addr = pc;
    assign pc_o      = pc_inc;

    always_comb begin
        imem_req     = 1'b0;
        instr_o      = 32'd0;
        ifid_flush_o = 1'b1;
        if (!rst) begin
            imem_req     = (state != ST_HOLD);
            ifid_flush_o = redirect
                         || (state == ST_DRAIN)
                         || ((state == ST_REQ) && !imem_rdy);
            unique case (1'b1)
                (state == ST_HOLD):               instr_o = hold_instr;
                (state == ST_REQ) && imem_rdy:    instr_o = imem_rdata;
                default:                          instr_o = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            hold_instr <= 32'd0;
            pend_pc    <= 32'd0;
        end else begin
            unique case (state)
                ST_REQ: begin
                    if (redirect) begin
                        if (imem_rdy) begin
                            pc <= rd_pc;
                        end else begin
                            pend_pc <= rd_pc;
                            state   <= ST_DRAIN;
                        end
                    end else if (imem_rdy) begin
                        if (ifid_write) begin
                            pc <= pc_inc;
                        end else begin
                            hold_instr <= imem_rdata;
                            state      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc    <= rd_pc;
                        state <= ST_REQ;
                    end else if (ifid_write) begin
                        pc    <= pc_inc;
                        state <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // The stale word is dropped; the newest redirect target wins.
                    if (imem_rdy) begin
                        pc    <= redirect ? rd_pc : pend_pc;
                        state <= ST_REQ;
                    end else if (redirect) begin
                        pend_pc <= rd_pc;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 imem_req  out  1  instruction-memory request valid.
REQ-005 imem_addr  out  32  word-aligned fetch address.
REQ-006 imem_rdy  in  1  memory returns imem_rdata this cycle for the current imem_addr.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 ifid_write  in  1  IF/ID register accepts a new entry this edge (0 = stall).
REQ-009 redirect  in  1  taken branch/jump; squash the fetch stream.
REQ-010 redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.
REQ-011 instr_o  out  32  instruction presented to IF/ID.
REQ-012 pc_o  out  32  fetch address + 4 of the presented instruction.
REQ-013 ifid_flush_o  out  1  inserts a bubble into IF/ID this edge.

Function
REQ-014 States: REQ (request outstanding), HOLD (fetched word buffered, IF/ID stalled), DRAIN (stale request completing after redirect).
REQ-015 Registers: pc, hold_instr, pend_pc, state.
REQ-016 imem_req = 1 in REQ and DRAIN, 0 in HOLD; imem_addr = pc in REQ, the stale address in DRAIN; imem_addr is stable while imem_req=1 and imem_rdy=0.
REQ-017 valid = (REQ and imem_rdy) or HOLD; instr_o = hold_instr in HOLD, imem_rdata when valid in REQ, else 0.
REQ-018 pc_o = pc + 4, modulo 2^32.
REQ-019 ifid_flush_o = redirect or DRAIN or (REQ and not imem_rdy).
REQ-020 REQ, imem_rdy, ifid_write, no redirect: pc <= pc+4, stay REQ. Throughput is 1 instruction/cycle with a zero-wait memory.
REQ-021 REQ, imem_rdy, not ifid_write, no redirect: hold_instr <= imem_rdata, go to HOLD, pc unchanged.
REQ-022 HOLD, ifid_write, no redirect: pc <= pc+4, go to REQ.
REQ-023 HOLD, not ifid_write: remain in HOLD; outputs stable.
REQ-024 Redirect has the highest priority over stall and delivery.
REQ-025 Redirect in REQ with imem_rdy: discard the word, pc <= redirect_pc, stay REQ.
REQ-026 Redirect in REQ without imem_rdy: pend_pc <= redirect_pc, go to DRAIN.
REQ-027 Redirect in HOLD: discard hold_instr, pc <= redirect_pc, go to REQ.
REQ-028 DRAIN: a further redirect overwrites pend_pc (latest wins). On imem_rdy, discard rdata, pc <= pend_pc (or redirect_pc if redirect is asserted that cycle), go to REQ.
REQ-029 pc+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000 without error.

Reset
REQ-030 While rst=1: state=REQ, pc=RESET_PC, hold_instr=0, pend_pc=0, imem_req forced 0, instr_o=0, ifid_flush_o=1, pc_o=RESET_PC+4.
REQ-031 Reset asserted mid-transaction (including DRAIN) abandons the transaction; the first request after deassertion is to RESET_PC.

Structure
REQ-032 Shared package holds the state encoding (REQ/HOLD/DRAIN, 2 bits) and the PC increment constant 4.
REQ-033 Single module, no sub-modules; the next-PC mux is inline.

Verification
REQ-034 Zero-wait memory (imem_rdy=1), ifid_write=1, RESET_PC=0: consecutive cycles present pc_o=4,8,12 with the matching imem_rdata and ifid_flush_o=0.
REQ-035 imem_rdy=0 for 3 cycles at addr 0x10: ifid_flush_o=1 for 3 cycles, addr held at 0x10; on rdy the word is delivered with pc_o=0x14.
REQ-036 Word 0xDEADBEEF returned while ifid_write=0 for 2 cycles: HOLD, imem_req=0, instr_o=0xDEADBEEF stable; on ifid_write=1, next imem_addr=pc+4.
REQ-037 Redirect to 0x0000_0103 during a wait at 0x20, then rdy: DRAIN, rdata discarded, next imem_addr=0x100, flush asserted throughout.
REQ-038 Redirect in HOLD plus simultaneous ifid_write=1: no delivery, flush=1, next imem_addr=redirect_pc.
REQ-039 pc=0xFFFF_FFFC delivered: next imem_addr=0; async rst mid-DRAIN returns to REQ at RESET_PC.
